// File: rtl/max6675_pkg.sv
// Shared constants, state encoding and frame packing for the MAX6675 emulator.
package max6675_pkg;

    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned TEMP_BITS   = 12;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = $clog2(FRAME_BITS + 1);

    localparam int unsigned BIT_LEAD   = 15;
    localparam int unsigned RESULT_MSB = 14;
    localparam int unsigned RESULT_LSB = 3;
    localparam int unsigned BIT_OPEN   = 2;
    localparam int unsigned BIT_DEV_ID = 1;
    localparam int unsigned BIT_TRI    = 0;

    typedef enum logic [1:0] {
        ST_CONVERT = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SHIFT   = 2'd2
    } state_t;

    // Frame as presented on miso, MSB first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [TEMP_BITS-1:0] result,
        input logic                 open_tc
    );
        logic [FRAME_BITS-1:0] f;
        f                        = '0;
        f[BIT_LEAD]              = 1'b0;
        f[RESULT_MSB:RESULT_LSB] = result;
        f[BIT_OPEN]              = open_tc;
        f[BIT_DEV_ID]            = 1'b0;
        f[BIT_TRI]               = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/max6675_emu_sync_edge.sv
// Multi-flop synchronizer with edge detection; edges are masked until the
// chain holds real samples after reset, so a level already away from idle is not an edge.
module sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    localparam int unsigned             FILL_W    = $clog2(STAGES + 2);
    localparam logic [FILL_W-1:0]       FILL_DONE = FILL_W'(STAGES + 1);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic [FILL_W-1:0] r_fill;
    logic              w_armed;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_fill <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            if (r_fill != FILL_DONE) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    assign w_armed  = (r_fill == FILL_DONE);
    assign o_level  = r_sync[STAGES-1];
    assign o_rise_c = w_armed & o_level & ~r_prev;
    assign o_fall_c = w_armed & ~o_level & r_prev;

endmodule

// File: rtl/max6675_emu.sv
// MAX6675 responder: conversion timer, abort-on-select and 16-bit frame shift-out
// of a host-supplied temperature.
module max6675_emu
    import max6675_pkg::*;
#(
    parameter int unsigned CONV_CYCLES = 11_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sclk,
    input  logic                 i_sel,
    input  logic [TEMP_BITS-1:0] i_temp_in,
    input  logic                 i_open_in,
    output logic                 o_miso,
    output logic                 o_miso_oe,
    output logic                 o_ready,
    output logic                 o_frame_done
);

    localparam int unsigned          TIMER_W    = $clog2(CONV_CYCLES);
    localparam logic [TIMER_W-1:0]   TIMER_LOAD = TIMER_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_FULL   = CNT_W'(FRAME_BITS);

    logic w_sel_s, w_sel_rise, w_sel_fall;
    logic w_sclk_s, w_sclk_rise, w_sclk_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sel (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_d      (i_sel),
        .o_level  (w_sel_s),
        .o_rise_c (w_sel_rise),
        .o_fall_c (w_sel_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_d      (i_sclk),
        .o_level  (w_sclk_s),
        .o_rise_c (w_sclk_rise),
        .o_fall_c (w_sclk_fall)
    );

    state_t                r_state, w_state_nxt;
    logic [TIMER_W-1:0]    r_timer, w_timer_nxt;
    logic [TEMP_BITS-1:0]  r_result, w_result_nxt;
    logic                  r_open_result, w_open_nxt;
    logic                  r_ready, w_ready_nxt;
    logic [FRAME_BITS-1:0] r_shreg, w_shreg_nxt;
    logic [CNT_W-1:0]      r_fall_cnt, w_fall_nxt;
    logic [CNT_W-1:0]      r_rise_cnt, w_rise_nxt;
    logic                  r_frame_done, w_done_nxt;
    logic                  r_miso_oe;
    logic [FRAME_BITS-1:0] w_frame;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_CONVERT;
            r_timer       <= TIMER_LOAD;
            r_result      <= '0;
            r_open_result <= 1'b0;
            r_ready       <= 1'b0;
            r_shreg       <= '0;
            r_fall_cnt    <= '0;
            r_rise_cnt    <= '0;
            r_frame_done  <= 1'b0;
            r_miso_oe     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_result      <= w_result_nxt;
            r_open_result <= w_open_nxt;
            r_ready       <= w_ready_nxt;
            r_shreg       <= w_shreg_nxt;
            r_fall_cnt    <= w_fall_nxt;
            r_rise_cnt    <= w_rise_nxt;
            r_frame_done  <= w_done_nxt;
            r_miso_oe     <= ~w_sel_s;
        end
    end

    // Next-state logic; sel edges are tested before sclk edges and before timer expiry.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_result_nxt = r_result;
        w_open_nxt   = r_open_result;
        w_ready_nxt  = r_ready;
        w_shreg_nxt  = r_shreg;
        w_fall_nxt   = r_fall_cnt;
        w_rise_nxt   = r_rise_cnt;
        w_done_nxt   = 1'b0;
        w_frame      = build_frame(r_result, r_open_result);

        unique case (r_state)
            ST_CONVERT: begin
                if (w_sel_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_shreg_nxt = w_frame;
                    w_fall_nxt  = '0;
                    w_rise_nxt  = '0;
                end else if (r_timer == '0) begin
                    w_state_nxt  = ST_IDLE;
                    w_result_nxt = i_temp_in;
                    w_open_nxt   = i_open_in;
                    w_ready_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            ST_IDLE: begin
                if (w_sel_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_shreg_nxt = w_frame;
                    w_fall_nxt  = '0;
                    w_rise_nxt  = '0;
                end
            end
            ST_SHIFT: begin
                if (w_sel_rise) begin
                    w_state_nxt = ST_CONVERT;
                    w_timer_nxt = TIMER_LOAD;
                    w_done_nxt  = (r_rise_cnt == CNT_FULL);
                    w_shreg_nxt = '0;
                end else if (!w_sel_fall) begin
                    if (w_sclk_fall && !w_sclk_s && r_fall_cnt != CNT_FULL) begin
                        w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], 1'b0};
                        w_fall_nxt  = r_fall_cnt + CNT_W'(1);
                    end
                    if (w_sclk_rise && r_rise_cnt != CNT_FULL) begin
                        w_rise_nxt = r_rise_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_CONVERT;
                w_timer_nxt = TIMER_LOAD;
            end
        endcase
    end

    assign o_miso       = r_shreg[FRAME_BITS-1];
    assign o_miso_oe    = r_miso_oe;
    assign o_ready      = r_ready;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_max6675_emu.sv
// Bench for max6675_emu: a cycle-timed SPI reader against a conversion/frame model.
module tb_max6675_emu;

    localparam int unsigned CONV = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        sel;
    logic [11:0] temp_in;
    logic        open_in;
    logic        miso;
    logic        miso_oe;
    logic        ready;
    logic        frame_done;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    logic [11:0] m_result;
    logic        m_open;
    logic        m_ready;

    max6675_emu #(.CONV_CYCLES(CONV)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sclk       (sclk),
        .i_sel        (sel),
        .i_temp_in    (temp_in),
        .i_open_in    (open_in),
        .o_miso       (miso),
        .o_miso_oe    (miso_oe),
        .o_ready      (ready),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reader: sample before each rising sclk, data changes after falling sclk.
    task automatic read_frame(input int n, output logic [31:0] rx);
        rx  = '0;
        sel = 1'b0;
        tick(6);
        check("oe_on", 32'(miso_oe), 32'd1);
        for (int i = 0; i < n; i++) begin
            rx   = {rx[30:0], miso};
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
            tick(5);
        end
        sel = 1'b1;
        tick(6);
        check("oe_off", 32'(miso_oe), 32'd0);
        check("miso_idle", 32'(miso), 32'd0);
    endtask

    // Wait, optionally let a conversion complete in the model, then read n bits.
    task automatic transaction(input string tag, input int wait_cyc, input int n, input bit conv);
        logic [31:0] rx;
        logic [31:0] f;
        logic [31:0] exp;
        int          d0;
        tick(wait_cyc);
        if (conv) begin
            m_result = temp_in;
            m_open   = open_in;
            m_ready  = 1'b1;
        end
        check("ready", 32'(ready), 32'(m_ready));
        f = {16'h0, 1'b0, m_result, m_open, 2'b00};
        if (n >= 16) exp = f << (n - 16);
        else         exp = f >> (16 - n);
        d0 = done_cnt;
        read_frame(n, rx);
        check(tag, rx, exp);
        check("frame_done", 32'(done_cnt - d0), (n >= 16) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int          w;
        int          n;
        bit          lng;
        int          d0;

        rst      = 1'b1;
        sel      = 1'b1;
        sclk     = 1'b0;
        temp_in  = 12'h190;
        open_in  = 1'b0;
        m_result = '0;
        m_open   = 1'b0;
        m_ready  = 1'b0;

        tick(5);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        tick(1);

        transaction("post_reset", 10, 16, 1'b0);
        tick(990);
        check("ready_early", 32'(ready), 32'd0);
        tick(30);
        check("ready_late", 32'(ready), 32'd1);
        m_result = temp_in;
        m_open   = open_in;
        m_ready  = 1'b1;
        transaction("t190", 10, 16, 1'b0);

        open_in = 1'b1;
        transaction("t190_open", CONV + 50, 16, 1'b1);

        temp_in = 12'hFFF;
        open_in = 1'b0;
        transaction("tfff", CONV + 50, 16, 1'b1);
        temp_in = 12'h010;
        transaction("abort", 500, 16, 1'b0);
        transaction("after_abort", CONV + 50, 16, 1'b1);

        temp_in = 12'($urandom);
        transaction("extra_clocks", CONV + 50, 20, 1'b1);
        transaction("short8", CONV + 50, 8, 1'b1);

        for (int i = 0; i < 10; i++) begin
            temp_in = 12'($urandom_range(0, 4095));
            open_in = 1'($urandom_range(0, 1));
            lng     = 1'($urandom_range(0, 1));
            w       = lng ? int'(CONV) + 50 + int'($urandom_range(0, 300))
                          : int'($urandom_range(20, CONV - 100));
            n       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                                  : int'($urandom_range(16, 20));
            transaction("rand", w, n, lng);
        end

        // Reset mid-frame with sel held low.
        sel = 1'b0;
        tick(6);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
            tick(5);
        end
        d0  = done_cnt;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        check("midrst_miso", 32'(miso), 32'd0);
        check("midrst_oe", 32'(miso_oe), 32'd1);
        check("midrst_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
            tick(5);
            check("midrst_miso_clk", 32'(miso), 32'd0);
        end
        sel = 1'b1;
        tick(6);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        m_result = '0;
        m_open   = 1'b0;
        m_ready  = 1'b0;
        transaction("post_midrst", 10, 16, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/max6675_emu.md
# max6675_emu

Board-side emulator of a MAX6675 thermocouple-to-digital converter: an SPI responder that answers the `max6675` reader plugin's 16-bit frames from a register-supplied temperature. It models the converter's conversion timer, abort-on-select behaviour and frame format, so reader plugins can be exercised on hardware-in-the-loop and simulation benches without a real sensor. It sits between the emulated sensor pins (`sclk`, `sel`, `miso`) and a host-written temperature register.

## Interface
- `CONV_CYCLES`, 11_000_000: conversion time in `clk` cycles (220 ms at 50 MHz); minimum 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `sclk`  in  1  SPI clock from the reader, asynchronous to `clk`.
- `sel`  in  1  chip select from the reader, active-low, asynchronous to `clk`.
- `temp_in`  in  12  emulated temperature in 0.25 °C units, unsigned.
- `open_in`  in  1  emulated open-thermocouple flag.
- `miso`  out  1  serial data to the reader.
- `miso_oe`  out  1  output enable for the `miso` pad driver.
- `ready`  out  1  at least one conversion has completed since reset.
- `frame_done`  out  1  one-cycle pulse: a complete 16-bit frame was clocked out.

## Operation
- Input conditioning:
  - `sclk` and `sel` each pass through 2 synchronizer flops, then an edge detector.
  - All decisions use the synchronized signals (`sel_s`, `sclk_s`) and their edge pulses.
- Frame format, MSB first:
  - bit 15 = 0.
  - bits 14:3 = `result`.
  - bit 2 = `open_result`.
  - bit 1 = 0 (device ID).
  - bit 0 = 0 (the real part tri-states here; the emulator drives 0).
- State machine: CONVERT, IDLE, SHIFT.
  - CONVERT: `timer` counts down from CONV_CYCLES-1. At 0:
    - `result <= temp_in` and `open_result <= open_in`.
    - `ready <= 1`.
    - Go to IDLE.
  - CONVERT with `sel` falling: abort. The conversion is discarded, `result` is unchanged, go to SHIFT.
  - IDLE with `sel` falling: go to SHIFT.
  - SHIFT on entry:
    - `shreg <= frame` and `miso <= frame[15]`.
    - `fall_cnt <= 0` and `rise_cnt <= 0`.
  - SHIFT on `sclk` falling:
    - `shreg` shifts left with 0 fill; `miso <= next bit`.
    - `fall_cnt` saturates at 16, so `miso` is 0 once all 16 bits have been presented.
  - SHIFT on `sclk` rising: `rise_cnt` increments, saturating at 16.
  - SHIFT with `sel` rising:
    - `frame_done` pulses if `rise_cnt == 16`.
    - `timer` reloads and the block goes to CONVERT (a new conversion starts).
- `miso_oe = ~sel_s`. While `sel_s` is high, `miso` is 0.
- `sel` edges take priority over `sclk` edges in the same cycle.
- Simultaneous `sel` falling and `timer == 0` in CONVERT: the abort wins and `result` is not updated.
- Reset values:
  - `miso = 0`, `miso_oe = 0`, `ready = 0`, `frame_done = 0`.
  - `result = 0`, `open_result = 0`.
  - State CONVERT with `timer = CONV_CYCLES-1`.
  - Synchronizer flops reset to idle levels: `sel` = 1, `sclk` = 0.
- Reset asserted mid-frame: the frame is abandoned and no `frame_done` is produced. If `sel` is still low after reset, the block waits for the next `sel` falling edge before shifting; `miso_oe` follows `sel_s`.
- Read before the first conversion: the frame carries `result = 0` and `ready = 0`.

## Timing
- Edge-to-action latency: 3 `clk` cycles.
  - `sel` falling to first bit valid on `miso`.
  - `sclk` falling to next bit valid.
  - `sel` rising to `frame_done`.
- Reader constraint: `sclk` high and low phases each ≥ 4 `clk` cycles. Faster `sclk` is out of spec and behaviour is undefined.
- Conversion completes CONV_CYCLES cycles after the CONVERT state is entered, i.e. after reset release or after the synchronized `sel` rising edge.
- `frame_done` is high for exactly 1 cycle.

## Structure
- Package `max6675_pkg`:
  - `FRAME_BITS = 16`, `TEMP_BITS = 12`, `SYNC_STAGES = 2`.
  - Frame bit-position constants.
  - State enum (CONVERT, IDLE, SHIFT).
- Sub-module `sync_edge`: parameterized synchronizer plus edge detector with a reset level. Outputs the level, a rise pulse and a fall pulse. It is instantiated twice, for `sclk` and `sel`.

## Test plan
- CONV_CYCLES=1000, `temp_in=12'h190`, `open_in=0`. Wait 1000 cycles, then read 16 bits → reader gets `16'h0C80`, `frame_done` pulses once.
- Same as above with `open_in=1` → `16'h0C84`.
- `temp_in=12'hFFF` converted. Change to `12'h010` and read at cycle 500 of the next conversion → returns `16'h7FF8` (abort). Wait 1000 cycles after `sel` rises, then read again → `16'h0080`.
- Read immediately after reset → `16'h0000`, `ready=0`, then `ready=1` 1000 cycles after `sel` rises.
- 20 `sclk` pulses in one frame → bits 16–19 read 0, `frame_done` pulses once. A frame aborted after 8 pulses gives no `frame_done`.
- Assert `rst` after 5 bits, keep `sel` low → `miso=0`, no `frame_done`. The next full frame reads `16'h0000`.
